// File: rtl/fp16_pack_out.sv
// FP32 -> FP16 (RNE) narrowing stage that pairs consecutive halves into one
// 32-bit packed word {second, first}; flush emits a lone half as {0x0000, half}.
module fp16_pack_out #(
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_single,
  output logic        ovf_sticky,
  output logic        inx_sticky,
  input  logic        clr_sticky
);

  typedef enum logic {ST_EMPTY, ST_HALF} state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_held, w_held_nx;
  logic        r_out_valid, w_out_valid_nx;
  logic [31:0] r_out_data, w_out_data_nx;
  logic        r_out_single, w_out_single_nx;
  logic        r_ovf, w_ovf_nx;
  logic        r_inx, w_inx_nx;

  logic        w_in_ready;
  logic        w_accept;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic [4:0]  w_hexp;
  logic        w_nrnd;
  logic [14:0] w_nsum;
  logic [3:0]  w_shamt;
  logic [34:0] w_sub;
  logic        w_srnd;
  logic [10:0] w_ssum;
  logic [15:0] w_half;
  logic        w_ovf;
  logic        w_inx;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  assign w_sign = in_data[31];
  assign w_exp  = in_data[30:23];
  assign w_man  = in_data[22:0];

  // Modular arithmetic on the low exponent bits: exp-112 and 112-exp are only
  // consumed in ranges where the narrow result is exact (112 = 16 mod 32 = 0 mod 16).
  assign w_hexp  = w_exp[4:0] - 5'd16;
  assign w_shamt = 4'd0 - w_exp[3:0];

  assign w_nrnd = w_man[12] && ((|w_man[11:0]) || w_man[13]);
  assign w_nsum = {w_hexp, w_man[22:13]} + {14'd0, w_nrnd};

  // Subnormal path: integer part lands in [34:25], guard at [24], sticky below.
  assign w_sub  = {1'b1, w_man, 11'd0} >> w_shamt;
  assign w_srnd = w_sub[24] && ((|w_sub[23:0]) || w_sub[25]);
  assign w_ssum = {1'b0, w_sub[34:25]} + {10'd0, w_srnd};

  always_comb begin
    w_half = '0;
    w_ovf  = 1'b0;
    w_inx  = 1'b0;
    if (w_exp == 8'hFF) begin
      w_half = {w_sign, (w_man != '0) ? 15'h7E00 : 15'h7C00};
    end else if (w_exp == 8'h00) begin
      w_half = {w_sign, 15'h0000};
      w_inx  = |w_man;
    end else if (w_exp <= 8'd101) begin
      w_half = {w_sign, 15'h0000};
      w_inx  = 1'b1;
    end else if (w_exp < 8'd113) begin
      w_half = {w_sign, 4'd0, w_ssum};
      w_inx  = |w_sub[24:0];
    end else if (w_exp >= 8'd143 || w_nsum[14:10] == 5'h1F) begin
      w_half = {w_sign, SATURATE ? 15'h7BFF : 15'h7C00};
      w_ovf  = 1'b1;
      w_inx  = 1'b1;
    end else begin
      w_half = {w_sign, w_nsum};
      w_inx  = |w_man[12:0];
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_held_nx       = r_held;
    w_out_valid_nx  = r_out_valid && !out_ready;
    w_out_data_nx   = r_out_data;
    w_out_single_nx = r_out_single;
    w_ovf_nx        = (r_ovf && !clr_sticky) || (w_accept && w_ovf);
    w_inx_nx        = (r_inx && !clr_sticky) || (w_accept && w_inx);
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          if (flush) begin
            w_out_valid_nx  = 1'b1;
            w_out_data_nx   = {16'h0000, w_half};
            w_out_single_nx = 1'b1;
          end else begin
            w_held_nx  = w_half;
            w_state_nx = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (w_accept) begin
          w_out_valid_nx  = 1'b1;
          w_out_data_nx   = {w_half, r_held};
          w_out_single_nx = 1'b0;
          w_state_nx      = ST_EMPTY;
        end else if (w_in_ready && flush) begin
          w_out_valid_nx  = 1'b1;
          w_out_data_nx   = {16'h0000, r_held};
          w_out_single_nx = 1'b1;
          w_state_nx      = ST_EMPTY;
        end
      end
      default: w_state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_held       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_single <= 1'b0;
      r_ovf        <= 1'b0;
      r_inx        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_held       <= w_held_nx;
      r_out_valid  <= w_out_valid_nx;
      r_out_data   <= w_out_data_nx;
      r_out_single <= w_out_single_nx;
      r_ovf        <= w_ovf_nx;
      r_inx        <= w_inx_nx;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_single = r_out_single;
  assign ovf_sticky = r_ovf;
  assign inx_sticky = r_inx;

endmodule

// File: tb/tb_fp16_pack_out.sv
// Scoreboard bench for fp16_pack_out: a real-arithmetic RNE reference model feeds
// an expected-word queue, drained by an independent output monitor.
module tb_fp16_pack_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;

  logic        in_ready0, out_valid0, out_single0, ovf0, inx0;
  logic        in_ready1, out_valid1, out_single1, ovf1, inx1;
  logic [31:0] out_data0, out_data1;

  always #5 clk = ~clk;

  fp16_pack_out #(.SATURATE(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_single(out_single0), .ovf_sticky(ovf0),
    .inx_sticky(inx0), .clr_sticky(clr_sticky)
  );

  fp16_pack_out #(.SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_single(out_single1), .ovf_sticky(ovf1),
    .inx_sticky(inx1), .clr_sticky(clr_sticky)
  );

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    bit          single;
  } word_t;

  word_t       sb[$];
  word_t       dir[$];
  int          total = 0;
  int          bad = 0;
  bit          pend = 1'b0;
  logic [15:0] held0, held1;
  bit          eo = 1'b0, ei = 1'b0;
  bit          last_acc;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic real p2(int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  // Exact value of the FP32 input, rounded to the FP16 grid with ties-to-even.
  function automatic void ref_conv(input logic [31:0] f, input bit sat,
                                   output logic [15:0] h, output bit ovf, output bit inx);
    logic [7:0]  ex;
    logic [22:0] mn;
    logic [14:0] mag;
    real         v, q, k, fr, r;
    int          e;
    longint      n;
    ex = f[30:23];
    mn = f[22:0];
    ovf = 1'b0;
    inx = 1'b0;
    if (ex == 8'hFF) begin
      mag = (mn != '0) ? 15'h7E00 : 15'h7C00;
    end else begin
      if (ex == 8'h00) v = real'(mn) * p2(-149);
      else v = real'({1'b1, mn}) * p2(int'(ex) - 150);
      if (v < p2(-14)) q = p2(-24);
      else begin
        e = -14;
        while (p2(e + 1) <= v) e++;
        q = p2(e - 10);
      end
      k = v / q;
      n = longint'($rtoi(k));
      fr = k - real'(n);
      if (fr > 0.5 || (fr == 0.5 && n[0])) n++;
      inx = (fr != 0.0);
      r = real'(n) * q;
      if (r > 65504.0) begin
        ovf = 1'b1;
        inx = 1'b1;
        mag = sat ? 15'h7BFF : 15'h7C00;
      end else if (r < p2(-14)) begin
        mag = 15'(n);
      end else begin
        e = -14;
        while (p2(e + 1) <= r) e++;
        mag = 15'((e + 15) * 1024 + $rtoi((r / p2(e) - 1.0) * 1024.0));
      end
    end
    h = {f[31], mag};
  endfunction

  function automatic void push(logic [31:0] w0, logic [31:0] w1, bit single);
    word_t w;
    w.w0 = w0;
    w.w1 = w1;
    w.single = single;
    if (dir.size() > 0) w = dir.pop_front();
    sb.push_back(w);
  endfunction

  function automatic void want(logic [31:0] w0, logic [31:0] w1, bit single);
    word_t w;
    w.w0 = w0;
    w.w1 = w1;
    w.single = single;
    dir.push_back(w);
  endfunction

  task automatic step(input bit v, input logic [31:0] d, input bit fl,
                      input bit ordy, input bit clr);
    logic [15:0] h0, h1;
    bit o0, x0, o1, x1;
    in_valid = v;
    in_data = d;
    flush = fl;
    out_ready = ordy;
    clr_sticky = clr;
    #1;
    chk("ovf_sticky", ovf0, eo);
    chk("inx_sticky", inx0, ei);
    chk("ovf_sticky_sat", ovf1, eo);
    chk("inx_sticky_sat", inx1, ei);
    last_acc = v && in_ready0;
    h0 = '0; h1 = '0; o0 = 0; x0 = 0; o1 = 0; x1 = 0;
    if (last_acc) begin
      ref_conv(d, 1'b0, h0, o0, x0);
      ref_conv(d, 1'b1, h1, o1, x1);
    end
    eo = (eo && !clr) || (last_acc && o0);
    ei = (ei && !clr) || (last_acc && x0);
    if (last_acc) begin
      if (pend) begin
        push({h0, held0}, {h1, held1}, 1'b0);
        pend = 1'b0;
      end else if (fl) begin
        push({16'h0, h0}, {16'h0, h1}, 1'b1);
      end else begin
        held0 = h0;
        held1 = h1;
        pend = 1'b1;
      end
    end else if (in_ready0 && fl && pend) begin
      push({16'h0, held0}, {16'h0, held1}, 1'b1);
      pend = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] d, input bit fl);
    int n = 0;
    do begin
      step(1'b1, d, fl, 1'b1, 1'b0);
      n++;
    end while (!last_acc && n < 50);
    chk("send_accepted", {31'd0, last_acc}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    pend = 1'b0;
    eo = 1'b0;
    ei = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_out_data", out_data0, 32'd0);
    chk("rst_out_single", {31'd0, out_single0}, 32'd0);
    chk("rst_ovf", {31'd0, ovf0}, 32'd0);
    chk("rst_inx", {31'd0, inx0}, 32'd0);
    chk("rst_out_valid_sat", {31'd0, out_valid1}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    logic [7:0]  ex;
    logic [31:0] sp [8];
    r = $urandom;
    sp = '{32'h7F800000, 32'hFFC00001, 32'h00000000, 32'h80000001,
           32'h477FE000, 32'h477FF000, 32'h387FF000, 32'hB3000001};
    case ($urandom % 4)
      0: ;
      1: begin
        ex = 8'(100 + $urandom % 46);
        r[30:23] = ex;
      end
      2: begin
        ex = 8'(100 + $urandom % 46);
        r[30:23] = ex;
        r[12:0] = 13'h1000;
      end
      default: r = sp[$urandom % 8];
    endcase
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every transfer and checks hold stability.
  initial begin
    word_t       e;
    bit          prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic        ps = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, out_valid0}, 32'd1);
          chk("hold_data", out_data0, pd);
          chk("hold_single", {31'd0, out_single0}, {31'd0, ps});
        end
        if (out_valid0 && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h want none", out_data0);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data0, e.w0);
            chk("out_data_sat", out_data1, e.w1);
            chk("out_single", {31'd0, out_single0}, {31'd0, e.single});
            chk("out_single_sat", {31'd0, out_single1}, {31'd0, e.single});
            chk("out_valid_sat", {31'd0, out_valid1}, 32'd1);
          end
        end
        prev_stall = out_valid0 && !out_ready;
        pd = out_data0;
        ps = out_single0;
      end
    end
  end

  initial begin
    do_reset();

    // pairing
    want(32'h40003C00, 32'h40003C00, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    chk("pair_latency_valid", {31'd0, out_valid0}, 32'd1);
    drain();

    // rounding
    want(32'h3C023C00, 32'h3C023C00, 1'b0);
    want(32'h00000001, 32'h00000001, 1'b0);
    send(32'h3F801000, 1'b0);
    send(32'h3F803000, 1'b0);
    send(32'h33800000, 1'b0);
    send(32'h33000000, 1'b0);
    chk("inx_after_round", {31'd0, inx0}, 32'd1);
    drain();

    // specials and overflow
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    want(32'h80007E00, 32'h80007E00, 1'b0);
    want(32'h00007C00, 32'h00007BFF, 1'b1);
    send(32'h7FC00000, 1'b0);
    send(32'h80000000, 1'b0);
    send(32'h477FF000, 1'b1);
    chk("ovf_after_65520", {31'd0, ovf0}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    want(32'h0000FC00, 32'h0000FC00, 1'b1);
    send(32'hFF800000, 1'b1);
    chk("ovf_after_neg_inf", {31'd0, ovf0}, 32'd0);
    drain();

    // flush variants
    want(32'h00003C00, 32'h00003C00, 1'b1);
    want(32'h00004000, 32'h00004000, 1'b1);
    want(32'h40003C00, 32'h40003C00, 1'b0);
    send(32'h3F800000, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    send(32'h40000000, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    drain();

    // backpressure
    want(32'h40003C00, 32'h40003C00, 1'b0);
    want(32'h44004200, 32'h44004200, 1'b0);
    want(32'hBC003800, 32'hBC003800, 1'b0);
    step(1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0);
      chk("stall_no_accept", {31'd0, last_acc}, 32'd0);
    end
    send(32'h40400000, 1'b0);
    send(32'h40800000, 1'b0);
    send(32'h3F000000, 1'b0);
    send(32'hBF800000, 1'b0);
    drain();

    // reset mid-pair
    send(32'h3F800000, 1'b0);
    do_reset();
    want(32'h3C004000, 32'h3C004000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h3F800000, 1'b0);
    drain();

    // random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 300 == 0) do_reset();
      else step(($urandom % 4) != 0, rnd_fp(), ($urandom % 8) == 0,
                ($urandom % 4) != 0, ($urandom % 16) == 0);
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    drain();
    chk("directed_consumed", dir.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
